// File: rtl/imc_pkg.sv
// Shared definitions for the in-memory-compute crossbar: controller register map,
// array size and the weight loader state encoding.
package imc_pkg;

   localparam logic [31:0] PROG_DATA_OFS  = 32'h0000_0000;
   localparam logic [31:0] PROG_ADDR_OFS  = 32'h0000_0004;
   localparam logic [31:0] V_INPUT_LO_OFS = 32'h0000_0008;
   localparam logic [31:0] V_INPUT_HI_OFS = 32'h0000_000C;
   localparam logic [31:0] RESULT_OFS     = 32'h0000_0010;

   localparam int unsigned IMC_N_CELLS = 64;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_WR_ADDR = 3'd3,
      ST_RD_CHK  = 3'd4,
      ST_WAIT_RV = 3'd5,
      ST_GAP     = 3'd6,
      ST_DONE    = 3'd7
   } loader_state_e;

   function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] ofs);
      return base + ofs;
   endfunction

endpackage

// File: rtl/imc_weight_loader.sv
// Streams weight bytes into the crossbar controller: per cell a PROG_DATA write,
// an optional readback check, then a PROG_ADDR write carrying the cell index.
module imc_weight_loader
   import imc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
   parameter int unsigned N_CELLS   = 64,
   parameter bit          VERIFY    = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        w_valid,
   output logic        w_ready,
   input  logic [7:0]  w_data,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_gnt,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [6:0]  cells_done
);

   localparam int unsigned CELLS_LIM = (N_CELLS > IMC_N_CELLS) ? IMC_N_CELLS : N_CELLS;
   localparam logic [6:0]  LAST_CNT  = 7'(CELLS_LIM);
   localparam logic [31:0] DATA_REG  = reg_addr(BASE_ADDR, PROG_DATA_OFS);
   localparam logic [31:0] ADDR_REG  = reg_addr(BASE_ADDR, PROG_ADDR_OFS);

   loader_state_e state_q, state_d;
   logic [7:0]    byte_q, byte_d;
   logic [6:0]    cells_q, cells_d;
   logic          abort_pend_q, abort_pend_d;
   logic          err_q, err_d;
   logic          m_req_q, m_req_d;
   logic          m_we_q, m_we_d;
   logic [31:0]   m_addr_q, m_addr_d;
   logic [31:0]   m_wdata_q, m_wdata_d;
   logic          w_ready_q, w_ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          rdata_hi_unused_s;

   assign rdata_hi_unused_s = ^m_rdata[31:8];

   // Next-state logic, then bus/stream outputs decoded from the next state so they leave flops.
   always_comb begin
      state_d      = state_q;
      byte_d       = byte_q;
      cells_d      = cells_q;
      abort_pend_d = abort_pend_q;
      err_d        = err_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_FETCH;
               cells_d      = 7'd0;
               err_d        = 1'b0;
               abort_pend_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (abort) begin
               state_d = ST_DONE;
            end else if (w_valid) begin
               byte_d  = w_data;
               state_d = ST_WR_DATA;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_WR_DATA: begin
            if (m_gnt) begin
               state_d = VERIFY ? ST_RD_CHK : ST_WR_ADDR;
            end else begin
               state_d = ST_WR_DATA;
            end
         end
         ST_RD_CHK: begin
            if (m_gnt) begin
               state_d = ST_WAIT_RV;
            end else begin
               state_d = ST_RD_CHK;
            end
         end
         ST_WAIT_RV: begin
            if (m_rvalid) begin
               if (m_rdata[7:0] != byte_q) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
               state_d = ST_WR_ADDR;
            end else begin
               state_d = ST_WAIT_RV;
            end
         end
         ST_WR_ADDR: begin
            if (m_gnt) begin
               state_d = ST_GAP;
            end else begin
               state_d = ST_WR_ADDR;
            end
         end
         ST_GAP: begin
            cells_d = cells_q + 7'd1;
            if ((cells_d == LAST_CNT) || abort || abort_pend_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // An abort seen mid-transaction is remembered until the next cell boundary.
      if ((state_q != ST_IDLE) && abort) begin
         abort_pend_d = 1'b1;
      end else begin
         abort_pend_d = abort_pend_d;
      end

      m_req_d   = 1'b0;
      m_we_d    = 1'b0;
      m_addr_d  = 32'h0000_0000;
      m_wdata_d = 32'h0000_0000;
      w_ready_d = 1'b0;
      done_d    = 1'b0;
      busy_d    = (state_d != ST_IDLE);

      case (state_d)
         ST_FETCH: begin
            w_ready_d = 1'b1;
         end
         ST_WR_DATA: begin
            m_req_d   = 1'b1;
            m_we_d    = 1'b1;
            m_addr_d  = DATA_REG;
            m_wdata_d = {24'h00_0000, byte_d};
         end
         ST_RD_CHK: begin
            m_req_d  = 1'b1;
            m_addr_d = DATA_REG;
         end
         ST_WR_ADDR: begin
            m_req_d   = 1'b1;
            m_we_d    = 1'b1;
            m_addr_d  = ADDR_REG;
            m_wdata_d = {26'h000_0000, cells_d[5:0]};
         end
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any bus transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         byte_q       <= 8'h00;
         cells_q      <= 7'd0;
         abort_pend_q <= 1'b0;
         err_q        <= 1'b0;
         m_req_q      <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= 32'h0000_0000;
         m_wdata_q    <= 32'h0000_0000;
         w_ready_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_q       <= byte_d;
         cells_q      <= cells_d;
         abort_pend_q <= abort_pend_d;
         err_q        <= err_d;
         m_req_q      <= m_req_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         w_ready_q    <= w_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign w_ready    = w_ready_q;
   assign m_req      = m_req_q;
   assign m_we       = m_we_q;
   assign m_addr     = m_addr_q;
   assign m_wdata    = m_wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign cells_done = cells_q;

endmodule

// File: tb/tb_imc_weight_loader.sv
// Scoreboard bench: two loaders (plain and readback-verifying) behind a shared weight stream,
// each with its own grant-pacing bus model.
module tb_imc_weight_loader;
   import imc_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0400;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b, abort, w_valid;
   logic [7:0]  w_data;
   logic        w_ready_a, m_req_a, m_we_a, m_gnt_a, m_rvalid_a, busy_a, done_a, err_a;
   logic [31:0] m_addr_a, m_wdata_a, m_rdata_a;
   logic [6:0]  cells_a;
   logic        w_ready_b, m_req_b, m_we_b, m_gnt_b, busy_b, done_b, err_b;
   logic        m_rvalid_b = 1'b0;
   logic [31:0] m_addr_b, m_wdata_b;
   logic [31:0] m_rdata_b = 32'h0;
   logic [6:0]  cells_b;
   logic [7:0]  last_b = 8'h00;

   int total = 0;
   int bad = 0;
   int gnt_delay = 0;
   int wc_a = 0;
   int wc_b = 0;
   int stab_bad = 0;
   bit sel = 1'b0;
   bit stop_drv = 1'b0;
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];

   logic        pend = 1'b0;
   logic        p_we = 1'b0;
   logic [31:0] p_addr = 32'h0;
   logic [31:0] p_wdata = 32'h0;

   logic        w_ready_s, req_s, we_s, gnt_s, busy_s, done_s, err_s;
   logic [31:0] addr_s, wdata_s;
   logic [6:0]  cells_s;

   always #5 clk = ~clk;

   imc_weight_loader #(.BASE_ADDR(BASE), .N_CELLS(64), .VERIFY(1'b0)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort),
      .w_valid(w_valid), .w_ready(w_ready_a), .w_data(w_data),
      .m_req(m_req_a), .m_we(m_we_a), .m_addr(m_addr_a), .m_wdata(m_wdata_a),
      .m_gnt(m_gnt_a), .m_rvalid(m_rvalid_a), .m_rdata(m_rdata_a),
      .busy(busy_a), .done(done_a), .err(err_a), .cells_done(cells_a));

   imc_weight_loader #(.BASE_ADDR(BASE), .N_CELLS(64), .VERIFY(1'b1)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort),
      .w_valid(w_valid), .w_ready(w_ready_b), .w_data(w_data),
      .m_req(m_req_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b),
      .m_gnt(m_gnt_b), .m_rvalid(m_rvalid_b), .m_rdata(m_rdata_b),
      .busy(busy_b), .done(done_b), .err(err_b), .cells_done(cells_b));

   assign m_rvalid_a = 1'b0;
   assign m_rdata_a  = 32'h0;
   assign m_gnt_a    = m_req_a && (wc_a >= gnt_delay);
   assign m_gnt_b    = m_req_b && (wc_b >= gnt_delay);

   assign w_ready_s = sel ? w_ready_b : w_ready_a;
   assign req_s     = sel ? m_req_b   : m_req_a;
   assign we_s      = sel ? m_we_b    : m_we_a;
   assign gnt_s     = sel ? m_gnt_b   : m_gnt_a;
   assign addr_s    = sel ? m_addr_b  : m_addr_a;
   assign wdata_s   = sel ? m_wdata_b : m_wdata_a;
   assign busy_s    = sel ? busy_b    : busy_a;
   assign done_s    = sel ? done_b    : done_a;
   assign err_s     = sel ? err_b     : err_a;
   assign cells_s   = sel ? cells_b   : cells_a;

   // Grant after gnt_delay waiting cycles; readback returns the last PROG_DATA byte, corrupted on cell 5.
   always @(posedge clk) begin
      wc_a <= (m_req_a && !m_gnt_a) ? wc_a + 1 : 0;
      wc_b <= (m_req_b && !m_gnt_b) ? wc_b + 1 : 0;
      m_rvalid_b <= m_req_b && m_gnt_b && !m_we_b;
      m_rdata_b  <= {24'h0, (cells_b == 7'd5) ? (last_b ^ 8'h01) : last_b};
      if (m_req_b && m_gnt_b && m_we_b && (m_addr_b == BASE)) last_b <= m_wdata_b[7:0];
   end

   // Capture accepted writes and flag any request whose payload moves while waiting for grant.
   always @(negedge clk) begin
      if (rst) begin
         pend <= 1'b0;
      end else begin
         if (req_s && gnt_s && we_s) obs_q.push_back({addr_s, wdata_s});
         if (pend && (!req_s || we_s !== p_we || addr_s !== p_addr || wdata_s !== p_wdata))
            stab_bad <= stab_bad + 1;
         pend    <= req_s && !gnt_s;
         p_we    <= we_s;
         p_addr  <= addr_s;
         p_wdata <= wdata_s;
      end
   end

   task automatic pulse_start(input bit which);
      if (which) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic drive_stream(input int nbytes, input int gap);
      int budget;
      for (int i = 0; i < nbytes; i++) begin
         if (stop_drv) break;
         if (gap > 0 && (i % 2) == 1) begin
            w_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         w_valid = 1'b1;
         w_data  = 8'(i);
         budget  = 0;
         while (!w_ready_s && !stop_drv && budget < 200) begin
            @(negedge clk);
            budget++;
         end
         if (!w_ready_s || stop_drv) break;
         exp_q.push_back({BASE, 24'h0, 8'(i)});
         exp_q.push_back({BASE + 32'h4, 26'h0, 6'(i)});
         @(negedge clk);
      end
      w_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit seen);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 3000) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (done_s) seen = 1'b1;
      end
      stop_drv = 1'b1;
   endtask

   task automatic prep(input bit which, input int delay);
      sel       = which;
      gnt_delay = delay;
      stop_drv  = 1'b0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (m_req_a !== 1'b0)     begin bad++; $display("FAIL rst_req got=%b exp=0", m_req_a); end
      total++; if (m_we_a !== 1'b0)      begin bad++; $display("FAIL rst_we got=%b exp=0", m_we_a); end
      total++; if (m_addr_a !== 32'h0)   begin bad++; $display("FAIL rst_addr got=%h exp=0", m_addr_a); end
      total++; if (m_wdata_a !== 32'h0)  begin bad++; $display("FAIL rst_wdata got=%h exp=0", m_wdata_a); end
      total++; if (w_ready_a !== 1'b0)   begin bad++; $display("FAIL rst_wready got=%b exp=0", w_ready_a); end
      total++; if (busy_a !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
      total++; if (done_a !== 1'b0)      begin bad++; $display("FAIL rst_done got=%b exp=0", done_a); end
      total++; if (err_b !== 1'b0)       begin bad++; $display("FAIL rst_err got=%b exp=0", err_b); end
      total++; if (cells_b !== 7'd0)     begin bad++; $display("FAIL rst_cells got=%0d exp=0", cells_b); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full;
      int cyc; bit seen; logic [63:0] e, o;
      prep(1'b0, 0);
      pulse_start(1'b0);
      fork
         drive_stream(64, 0);
         wait_done(cyc, seen);
      join
      total++; if (seen !== 1'b1)     begin bad++; $display("FAIL full_done got=%b exp=1", seen); end
      total++; if (cyc !== 256)       begin bad++; $display("FAIL full_cycles got=%0d exp=256", cyc); end
      total++; if (cells_s !== 7'd64) begin bad++; $display("FAIL full_cells got=%0d exp=64", cells_s); end
      total++; if (err_s !== 1'b0)    begin bad++; $display("FAIL full_err got=%b exp=0", err_s); end
      total++; if (obs_q.size() !== 128) begin bad++; $display("FAIL full_nwr got=%0d exp=128", obs_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL full_wr got=%h exp=%h", o, e); end
      end
      @(negedge clk);
      total++; if (done_s !== 1'b0)   begin bad++; $display("FAIL full_done_pulse got=%b exp=0", done_s); end
      total++; if (busy_s !== 1'b0)   begin bad++; $display("FAIL full_idle_busy got=%b exp=0", busy_s); end
   endtask

   task automatic test_backpressure;
      int cyc; bit seen; int stab0; logic [63:0] e, o;
      prep(1'b0, 3);
      stab0 = stab_bad;
      pulse_start(1'b0);
      fork
         drive_stream(64, 2);
         wait_done(cyc, seen);
         begin : restart_probe
            int b;
            b = 0;
            while (cells_s != 7'd30 && b < 5000) begin @(negedge clk); b++; end
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
         end
      join
      total++; if (seen !== 1'b1)       begin bad++; $display("FAIL bp_done got=%b exp=1", seen); end
      total++; if (cells_s !== 7'd64)   begin bad++; $display("FAIL bp_cells got=%0d exp=64", cells_s); end
      total++; if (stab_bad !== stab0)  begin bad++; $display("FAIL bp_stable got=%0d exp=%0d", stab_bad, stab0); end
      total++; if (obs_q.size() !== 128) begin bad++; $display("FAIL bp_nwr got=%0d exp=128", obs_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL bp_wr got=%h exp=%h", o, e); end
      end
      @(negedge clk);
   endtask

   task automatic test_verify;
      int cyc; bit seen; int first_err; logic [63:0] e, o;
      prep(1'b1, 1);
      first_err = -1;
      pulse_start(1'b1);
      fork
         drive_stream(64, 0);
         wait_done(cyc, seen);
         begin : err_watch
            int b;
            b = 0;
            while (!err_s && !done_s && b < 5000) begin @(negedge clk); b++; end
            if (err_s) first_err = int'(cells_s);
         end
      join
      total++; if (seen !== 1'b1)     begin bad++; $display("FAIL vfy_done got=%b exp=1", seen); end
      total++; if (first_err !== 5)   begin bad++; $display("FAIL vfy_err_cell got=%0d exp=5", first_err); end
      total++; if (err_s !== 1'b1)    begin bad++; $display("FAIL vfy_err got=%b exp=1", err_s); end
      total++; if (cells_s !== 7'd64) begin bad++; $display("FAIL vfy_cells got=%0d exp=64", cells_s); end
      total++; if (obs_q.size() !== 128) begin bad++; $display("FAIL vfy_nwr got=%0d exp=128", obs_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL vfy_wr got=%h exp=%h", o, e); end
      end
      @(negedge clk);
   endtask

   task automatic test_abort;
      int cyc; bit seen; logic [63:0] e, o; bit idle_act;
      prep(1'b0, 0);
      idle_act = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (busy_s || done_s) idle_act = 1'b1;
      end
      total++; if (idle_act !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", idle_act); end
      pulse_start(1'b0);
      fork
         drive_stream(64, 0);
         wait_done(cyc, seen);
         begin : abort_probe
            int b;
            b = 0;
            while (!(req_s && we_s && addr_s == BASE && cells_s == 7'd10) && b < 5000) begin
               @(negedge clk); b++;
            end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
         end
      join
      total++; if (seen !== 1'b1)     begin bad++; $display("FAIL abort_done got=%b exp=1", seen); end
      total++; if (cells_s !== 7'd11) begin bad++; $display("FAIL abort_cells got=%0d exp=11", cells_s); end
      total++; if (obs_q.size() !== 22) begin bad++; $display("FAIL abort_nwr got=%0d exp=22", obs_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL abort_wr got=%h exp=%h", o, e); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int cyc; bit seen; bit done_seen; logic [63:0] e, o;
      prep(1'b0, 3);
      done_seen = 1'b0;
      pulse_start(1'b0);
      fork
         drive_stream(64, 0);
         begin : rst_probe
            int b;
            b = 0;
            while (!(req_s && we_s && addr_s == BASE + 32'h4 && cells_s == 7'd20) && b < 5000) begin
               @(negedge clk); b++;
            end
            total++; if (b >= 5000) begin bad++; $display("FAIL rmid_reach got=timeout exp=WR_ADDR cell 20"); end
            rst = 1'b1;
            #1;
            total++; if (req_s !== 1'b0)    begin bad++; $display("FAIL rmid_req got=%b exp=0", req_s); end
            total++; if (busy_s !== 1'b0)   begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy_s); end
            total++; if (cells_s !== 7'd0)  begin bad++; $display("FAIL rmid_cells got=%0d exp=0", cells_s); end
            stop_drv = 1'b1;
            @(negedge clk);
         end
      join
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done_s) done_seen = 1'b1;
      end
      total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL rmid_nodone got=%b exp=0", done_seen); end
      prep(1'b0, 0);
      pulse_start(1'b0);
      fork
         drive_stream(64, 0);
         wait_done(cyc, seen);
      join
      total++; if (seen !== 1'b1)     begin bad++; $display("FAIL reload_done got=%b exp=1", seen); end
      total++; if (cells_s !== 7'd64) begin bad++; $display("FAIL reload_cells got=%0d exp=64", cells_s); end
      total++; if (obs_q.size() !== 128) begin bad++; $display("FAIL reload_nwr got=%0d exp=128", obs_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL reload_wr got=%h exp=%h", o, e); end
      end
      @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      abort   = 1'b0;
      w_valid = 1'b0;
      w_data  = 8'h00;
      test_reset();
      test_full();
      test_backpressure();
      test_verify();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imc_weight_loader.md
IMC_WEIGHT_LOADER -- requirements
Module: imc_weight_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h400, the crossbar controller register base (PROG_DATA = BASE, PROG_ADDR = BASE+4).
REQ-002 SHALL have parameter N_CELLS, default 64, the number of weights per load; legal range 1..64.
REQ-003 SHALL have parameter VERIFY, default 0; when 1, each PROG_DATA write is read back and compared.
REQ-004 SHALL use one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- start  in  1  one-cycle pulse that begins a load
- abort  in  1  terminates a load at the next cell boundary
- w_valid  in  1  weight stream valid
- w_ready  out  1  weight stream ready
- w_data  in  8  weight byte
- m_req  out  1  bus request
- m_we  out  1  bus write enable
- m_addr  out  32  bus address
- m_wdata  out  32  bus write data
- m_gnt  in  1  bus grant
- m_rvalid  in  1  read data valid, one cycle after grant
- m_rdata  in  32  read data
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky readback mismatch
- cells_done  out  7  count of cells programmed in the current/last load

Function
REQ-005 SHALL implement FSM states IDLE, FETCH, WR_DATA, WR_ADDR, RD_CHK, WAIT_RV, GAP, DONE.
REQ-006 IDLE: start=1 -> FETCH; clears cells_done and err; busy=1 in every state except IDLE.
REQ-007 FETCH: w_ready=1 only in this state; on w_valid latches w_data -> WR_DATA; abort in FETCH -> DONE.
REQ-008 WR_DATA: m_req=1, m_we=1, m_addr=BASE_ADDR, m_wdata={24'b0,byte}; held stable until m_gnt; on grant -> RD_CHK if VERIFY, else WR_ADDR.
REQ-009 RD_CHK: m_req=1, m_we=0, m_addr=BASE_ADDR until m_gnt -> WAIT_RV; WAIT_RV: on m_rvalid, m_rdata[7:0] != byte sets err -> WR_ADDR.
REQ-010 WR_ADDR: m_req=1, m_we=1, m_addr=BASE_ADDR+4, m_wdata={26'b0,cell_idx[5:0]} until m_gnt -> GAP.
REQ-011 GAP: exactly one cycle with m_req=0; increments cells_done; then -> DONE if cells_done reaches N_CELLS or abort is high, else FETCH.
REQ-012 DONE: done=1 for one cycle -> IDLE; cells_done holds its final value until the next start.
REQ-013 cell_idx SHALL equal cells_done[5:0]; programming order is 0..N_CELLS-1, no wrap.
REQ-014 m_req SHALL be 0 in IDLE, FETCH, WAIT_RV, GAP and DONE; address/data SHALL not change while m_req=1 and m_gnt=0.
REQ-015 start while busy SHALL be ignored; abort while IDLE SHALL be ignored.
REQ-016 abort during a bus transaction SHALL NOT cut it; the current cell completes (incl. PROG_ADDR) before DONE.
REQ-017 Minimum cost per cell with zero-wait grant, VERIFY=0: 4 cycles (FETCH, WR_DATA, WR_ADDR, GAP).

Reset
REQ-018 rst=1 SHALL force IDLE asynchronously: m_req=0, m_we=0, m_addr=0, m_wdata=0, w_ready=0, busy=0, done=0, err=0, cells_done=0.
REQ-019 Reset mid-load SHALL abandon the load without completing the bus transaction; no done pulse.

Structure
REQ-020 A shared package imc_pkg SHALL hold the register offsets (PROG_DATA 0x0, PROG_ADDR 0x4, V_INPUT_LO 0x8, V_INPUT_HI 0xC, RESULT 0x10), the cell count constant 64 and the loader state enum.
REQ-021 SHALL be a single module with no sub-modules; the bus port set SHALL connect directly to the crossbar controller's req/we/addr/wdata/gnt/rvalid/rdata.

Verification
REQ-022 Full load: start, stream bytes 0x00..0x3F, gnt tied to req -> 64 write pairs, PROG_ADDR data 0..63, done pulse after 256 cycles, cells_done=64, err=0.
REQ-023 Backpressure: gnt delayed 3 cycles per request, w_valid gapped -> address/data stable while waiting, same 64 pairs, no lost byte.
REQ-024 VERIFY=1, model returns byte XOR 0x01 on cell 5 -> err=1 from WAIT_RV of cell 5, load still completes with cells_done=64.
REQ-025 abort asserted during WR_DATA of cell 10 -> cell 10 PROG_ADDR write issued, done pulse, cells_done=11.
REQ-026 rst pulsed during WR_ADDR of cell 20 -> m_req=0 same cycle, busy=0, cells_done=0, no done pulse; fresh start reloads from cell 0.
REQ-027 End-to-end with the crossbar controller: load weights, write V_INPUT_LO/HI, read RESULT words -> match reference model currents.
